alu_bist: RTL and testbench

- Built-in self-test driver for the 32-bit ALU: the stimulus/checker end of the ALU operand/result interface, in hardware.
- Generates pseudo-random operand pairs from an LFSR and drives them to the ALU with each supported op code.
- Checks the ALU's z and ex against an internal golden model and reports pass/fail, a failure count and the first failing vector.
- Sits beside the ALU in the datapath; used for power-on self-test and lab bring-up.

---
 rtl/alu_bist_if.sv | 26 ++
 rtl/alu_bist.sv | 163 ++++++++++++++++
 tb/tb_alu_bist.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_bist_if.sv
// ALU operand/result bus between the self-test driver (master) and the ALU (slave).
interface alu_bist_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_z;
  logic             alu_ex;

  modport master (
    output alu_a,
    output alu_b,
    output alu_op,
    input  alu_z,
    input  alu_ex
  );

  modport slave (
    input  alu_a,
    input  alu_b,
    input  alu_op,
    output alu_z,
    output alu_ex
  );
endinterface

// File: rtl/alu_bist.sv
// Built-in self-test driver for the ALU: LFSR operand pairs are applied for each op code
// and the ALU's result and zero flag are checked against an internal golden model.
module alu_bist #(
  parameter int          WIDTH    = 32,
  parameter int          NUM_VECS = 10,
  parameter logic [31:0] SEED     = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop_on_fail,
  alu_bist_if.master       alu,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      fail_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [2:0]       fail_op,
  output logic [WIDTH-1:0] fail_z
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_DRIVE  = 2'd1;
  localparam logic [1:0]  S_SAMPLE = 2'd2;
  localparam logic [1:0]  S_DONE   = 2'd3;

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [31:0] SEED_NZ  = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [15:0] VEC_LAST = 16'(NUM_VECS - 1);

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    logic fb;
    fb = l[31] ^ l[21] ^ l[1] ^ l[0];
    return {l[30:0], fb};
  endfunction

  function automatic logic [2:0] op_code(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      default: return 3'b110;
    endcase
  endfunction

  // Reference ALU; ADD/SUB wrap modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] golden(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [2:0]       op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      default: return '0;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  logic [1:0]       state;
  logic [31:0]      lfsr;
  logic [15:0]      vec;
  logic [1:0]       op_idx;
  logic [WIDTH-1:0] exp_z;

  logic [31:0]      lfsr_n1;
  logic [31:0]      lfsr_n2;
  logic [2:0]       cur_op;
  logic             mismatch;
  logic             last_vec;
  logic [15:0]      fail_count_nxt;

  always_comb begin
    lfsr_n1        = lfsr_step(lfsr);
    lfsr_n2        = lfsr_step(lfsr_n1);
    cur_op         = op_code(op_idx);
    mismatch       = (alu.alu_z != exp_z) || (alu.alu_ex != (exp_z == '0));
    last_vec       = (op_idx == 2'd3) && (vec == VEC_LAST);
    fail_count_nxt = mismatch ? sat_inc(fail_count) : fail_count;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      lfsr       <= SEED_NZ;
      vec        <= '0;
      op_idx     <= '0;
      exp_z      <= '0;
      alu.alu_a  <= '0;
      alu.alu_b  <= '0;
      alu.alu_op <= 3'b000;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_count <= '0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_op    <= '0;
      fail_z     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            lfsr       <= SEED_NZ;
            vec        <= '0;
            op_idx     <= '0;
            fail_count <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_op    <= '0;
            fail_z     <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            state      <= S_DRIVE;
          end
        end

        // Operands are two consecutive LFSR states; the LFSR then advances past both.
        S_DRIVE: begin
          alu.alu_a  <= WIDTH'(lfsr);
          alu.alu_b  <= WIDTH'(lfsr_n1);
          alu.alu_op <= cur_op;
          exp_z      <= golden(WIDTH'(lfsr), WIDTH'(lfsr_n1), cur_op);
          lfsr       <= lfsr_n2;
          state      <= S_SAMPLE;
        end

        // fail_count is still zero only before the first mismatch of the run.
        S_SAMPLE: begin
          fail_count <= fail_count_nxt;
          if (mismatch && (fail_count == 16'd0)) begin
            fail_a  <= alu.alu_a;
            fail_b  <= alu.alu_b;
            fail_op <= alu.alu_op;
            fail_z  <= alu.alu_z;
          end
          if (last_vec || (mismatch && stop_on_fail)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (fail_count_nxt == 16'd0);
            state <= S_DONE;
          end else begin
            if (vec == VEC_LAST) begin
              vec    <= '0;
              op_idx <= op_idx + 2'd1;
            end else begin
              vec <= vec + 16'd1;
            end
            state <= S_DRIVE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist: a fault-injectable ALU model drives the DUT and a
// behavioural model predicts every run cycle by cycle.
module tb_alu_bist;
  localparam int WIDTH    = 32;
  localparam int NUM_VECS = 10;
  localparam int NV       = 4 * NUM_VECS;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             stop_on_fail;
  logic             busy, done, pass;
  logic [15:0]      fail_count;
  logic [WIDTH-1:0] fail_a, fail_b, fail_z;
  logic [2:0]       fail_op;

  int               fault;
  logic [31:0]      key;
  logic [31:0]      xmask;

  int checks = 0;
  int passes = 0;

  logic [31:0] va [NV];
  logic [31:0] vb [NV];
  logic [2:0]  vop[NV];

  alu_bist_if #(.WIDTH(WIDTH)) alu_bus ();

  alu_bist #(.WIDTH(WIDTH), .NUM_VECS(NUM_VECS), .SEED(32'h0000_0001)) dut (
    .clk(clk), .reset(reset), .start(start), .stop_on_fail(stop_on_fail),
    .alu(alu_bus),
    .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
    .fail_a(fail_a), .fail_b(fail_b), .fail_op(fail_op), .fail_z(fail_z)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] golden(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      default: return 32'd0;
    endcase
  endfunction

  // ALU under test: 0 correct, 1 SUB adds, 2 SUB adds and OR ands,
  // 3 zero flag stuck high, 4 operand-keyed random result corruption.
  function automatic logic [31:0] env_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op, input int f,
                                          input logic [31:0] k, input logic [31:0] xm);
    logic [31:0] r;
    r = golden(a, b, op);
    if ((f == 1 || f == 2) && op == 3'b110) r = a + b;
    if (f == 2 && op == 3'b001) r = a & b;
    if (f == 4 && ((a ^ k) & 32'd3) == 32'd0) r = r ^ xm;
    return r;
  endfunction

  function automatic logic env_ex(input logic [31:0] z, input int f);
    return (f == 3) ? 1'b1 : (z == 32'd0);
  endfunction

  assign alu_bus.alu_z  = env_alu(alu_bus.alu_a, alu_bus.alu_b, alu_bus.alu_op, fault, key, xmask);
  assign alu_bus.alu_ex = env_ex(alu_bus.alu_z, fault);

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  // Walk the vector list applying the run rules; returns the last checked vector,
  // the mismatch count and the first mismatching vector.
  task automatic predict(input int f, input bit stop, output int kend, output int fc,
                         output int ff);
    logic [31:0] z, g;
    logic        mism;
    fc = 0; ff = -1; kend = NV - 1;
    for (int k = 0; k < NV; k++) begin
      z    = env_alu(va[k], vb[k], vop[k], f, key, xmask);
      g    = golden(va[k], vb[k], vop[k]);
      mism = (z != g) || (env_ex(z, f) != (g == 32'd0));
      if (mism) begin
        if (fc == 0) ff = k;
        fc++;
      end
      if (mism && stop) begin
        kend = k;
        break;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_alu_a"}, alu_bus.alu_a, 0);
    check({tag, "_alu_b"}, alu_bus.alu_b, 0);
    check({tag, "_alu_op"}, alu_bus.alu_op, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_fail_count"}, fail_count, 0);
    check({tag, "_fail_abz"}, {fail_a ^ fail_b ^ fail_z, 29'd0, fail_op}, 0);
  endtask

  // glitch: edge number (after start) at which a stray start pulse is driven;
  // -1 none, -2 random edge while the run is in progress.
  task automatic do_run(input int f, input bit stop, input int glitch, output int kend_o,
                        output int fc_o);
    int kend, fc, ff, edone, g, k;
    fault = f;
    stop_on_fail = stop;
    predict(f, stop, kend, fc, ff);
    kend_o = kend;
    fc_o   = fc;
    edone  = 2 * kend + 2;
    g = (glitch == -2) ? $urandom_range(1, edone - 1) : glitch;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("start_fail_count", fail_count, 0);
    for (int e = 1; e <= edone + 4; e++) begin
      @(negedge clk); start = (e == g);
      @(posedge clk); #1; start = 1'b0;
      k = (e <= edone) ? (e - 1) / 2 : kend;
      check("alu_a", alu_bus.alu_a, va[k]);
      check("alu_b", alu_bus.alu_b, vb[k]);
      check("alu_op", alu_bus.alu_op, vop[k]);
      if (e == 1) begin
        check("first_alu_a", alu_bus.alu_a, 32'h1);
        check("first_alu_b", alu_bus.alu_b, 32'h3);
      end
      if (e < edone) begin
        check("run_busy", busy, 1);
        check("run_done", done, 0);
      end else begin
        check("end_busy", busy, 0);
        check("end_done", done, 1);
        check("end_pass", pass, (fc == 0));
        check("end_fail_count", fail_count, fc);
        if (fc > 0) begin
          check("fail_a", fail_a, va[ff]);
          check("fail_b", fail_b, vb[ff]);
          check("fail_op", fail_op, vop[ff]);
          check("fail_z", fail_z, env_alu(va[ff], vb[ff], vop[ff], f, key, xmask));
        end else begin
          check("fail_regs_clear", {fail_a ^ fail_b ^ fail_z, 29'd0, fail_op}, 0);
        end
      end
    end
  endtask

  initial begin
    logic [31:0] l;
    logic [2:0]  ops [4];
    int kend, fc;
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b110;
    l = 32'h1;
    for (int k = 0; k < NV; k++) begin
      va[k]  = l;
      vb[k]  = lfsr_next(l);
      l      = lfsr_next(vb[k]);
      vop[k] = ops[k / NUM_VECS];
    end
    check("model_a0", va[0], 32'd1);
    check("model_b0", vb[0], 32'd3);
    check("model_a1", va[1], 32'd6);
    check("model_b1", vb[1], 32'd13);

    fault = 0; key = 0; xmask = 0;
    reset = 1'b1; start = 1'b0; stop_on_fail = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk); reset = 1'b0;

    do_run(0, 1'b0, -1, kend, fc);
    check("good_done_edge", 2 * kend + 2, 80);
    check("good_fail_count", fc, 0);

    do_run(1, 1'b0, -1, kend, fc);
    check("sub_fault_count", fc, 10);

    do_run(2, 1'b1, -1, kend, fc);
    check("stop_vector", kend, 10);
    check("stop_fail_count", fc, 1);

    do_run(3, 1'b0, 15, kend, fc);

    // Asynchronous reset in the middle of a run.
    fault = 0; stop_on_fail = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (30) @(posedge clk);
    #2 reset = 1'b1;
    #1 check_all_zero("midrun_reset");
    @(negedge clk); reset = 1'b0;
    do_run(0, 1'b0, -1, kend, fc);

    for (int r = 0; r < 4; r++) begin
      key   = $urandom;
      xmask = $urandom | 32'h1;
      do_run(4, 1'($urandom_range(0, 1)), -2, kend, fc);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
